// File: rtl/mem_share_arbiter.sv
// Round-robin sharing of one single-port memory macro between PORTS requesters.
// One access per cycle reaches the macro; read data is steered back to its requester.
module mem_share_arbiter #(
  parameter int PORTS      = 2,
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 256,
  parameter int MASK       = 4,
  parameter int RD_LATENCY = 1,
  parameter int AW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PORTS-1:0]       req_valid,
  output logic [PORTS-1:0]       req_ready,
  input  logic [PORTS-1:0]       req_we,
  input  logic [PORTS*AW-1:0]    req_addr,
  input  logic [PORTS*WIDTH-1:0] req_wdata,
  input  logic [PORTS*MASK-1:0]  req_mask,
  output logic [PORTS-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  output logic [MASK-1:0]        mem_mask,
  input  logic [WIDTH-1:0]       mem_rdata
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [AW:0] HMAX = (AW+1)'(HEIGHT);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win, win_hi, win_lo;
  logic             hit_hi, hit_lo, xfer;
  logic [PORTS-1:0] grant;
  logic             w_we;
  logic [AW-1:0]    w_addr;
  logic [WIDTH-1:0] w_wdata;
  logic [MASK-1:0]  w_mask;
  logic             in_range;

  // Stage 0 lines up with the macro access cycle, so the top stage is RD_LATENCY
  // cycles behind mem_en.
  logic [RD_LATENCY:0]         pipe_vld;
  logic [RD_LATENCY:0]         pipe_err;
  logic [RD_LATENCY:0][PW-1:0] pipe_id;

  // Wrapped search done as two ordered scans: first valid at/above ptr, else first valid overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (req_valid[p] && !hit_lo) begin
        hit_lo = 1'b1;
        win_lo = PW'(p);
      end
      if (req_valid[p] && (PW'(p) >= ptr) && !hit_hi) begin
        hit_hi = 1'b1;
        win_hi = PW'(p);
      end
    end
    xfer = hit_hi || hit_lo;
    win  = hit_hi ? win_hi : win_lo;
  end

  always_comb begin
    grant   = '0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_mask  = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (xfer && (win == PW'(p))) begin
        grant[p] = 1'b1;
        w_we     = req_we[p];
        w_addr   = req_addr[p*AW +: AW];
        w_wdata  = req_wdata[p*WIDTH +: WIDTH];
        w_mask   = req_mask[p*MASK +: MASK];
      end
    end
    in_range  = ({1'b0, w_addr} < HMAX);
    req_ready = reset_n ? grant : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mask  <= '0;
      pipe_vld  <= '0;
      pipe_err  <= '0;
      pipe_id   <= '0;
    end else begin
      mem_en <= xfer && in_range;
      if (xfer) begin
        ptr <= (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;
      end
      if (xfer && in_range) begin
        mem_we    <= w_we;
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
        mem_mask  <= w_we ? w_mask : '0;
      end
      pipe_vld <= {pipe_vld[RD_LATENCY-1:0], xfer && !w_we};
      pipe_err <= {pipe_err[RD_LATENCY-1:0], !in_range};
      pipe_id  <= {pipe_id[RD_LATENCY-1:0], win};
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (pipe_vld[RD_LATENCY]) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        rsp_valid[p] = (pipe_id[RD_LATENCY] == PW'(p));
      end
      rsp_err = pipe_err[RD_LATENCY];
      if (!pipe_err[RD_LATENCY]) rsp_rdata = mem_rdata;
    end
  end

`ifndef SYNTHESIS
  for (genvar i = 0; i < PORTS; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!reset_n)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_we[i]) && $stable(req_addr[i*AW +: AW]) &&
         $stable(req_wdata[i*WIDTH +: WIDTH]) && $stable(req_mask[i*MASK +: MASK])));
  end
`endif

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Bench for mem_share_arbiter: behavioural macro, queue-based reference model,
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_mem_share_arbiter;

  localparam int PORTS  = 3;
  localparam int WIDTH  = 32;
  localparam int HEIGHT = 200;
  localparam int MASK   = 4;
  localparam int RDL    = 3;
  localparam int AW     = 8;
  localparam int LW     = WIDTH / MASK;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [PORTS-1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [PORTS*AW-1:0]    req_addr;
  logic [PORTS*WIDTH-1:0] req_wdata;
  logic [PORTS*MASK-1:0]  req_mask;
  logic [WIDTH-1:0]       rsp_rdata, mem_wdata, mem_rdata;
  logic                   rsp_err, mem_en, mem_we;
  logic [AW-1:0]          mem_addr;
  logic [MASK-1:0]        mem_mask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_share_arbiter #(
    .PORTS(PORTS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
  );

  function automatic logic [WIDTH-1:0] init_word(input int a);
    if (a == 5) return 32'hDEADBEEF;
    if (a == 3) return 32'h11223344;
    return WIDTH'(32'h9E3779B9 * (a + 1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory macro: lane-masked writes, reads return RDL cycles after mem_en.
  bit               loaded = 1'b0;
  logic [WIDTH-1:0] macro_mem [HEIGHT];
  logic [WIDTH-1:0] rd_data [RDL];
  logic [RDL-1:0]   rd_vld = '0;
  logic [WIDTH-1:0] gcnt = '0;

  always @(posedge clk) begin
    gcnt <= gcnt + 1;
    if (!loaded) begin
      for (int i = 0; i < HEIGHT; i++) macro_mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (mem_en && mem_we && int'(mem_addr) < HEIGHT) begin
      for (int l = 0; l < MASK; l++)
        if (mem_mask[l]) macro_mem[mem_addr][l*LW +: LW] <= mem_wdata[l*LW +: LW];
    end
    rd_vld[0]  <= mem_en && !mem_we;
    rd_data[0] <= (int'(mem_addr) < HEIGHT) ? macro_mem[mem_addr] : '0;
    for (int s = 1; s < RDL; s++) begin
      rd_vld[s]  <= rd_vld[s-1];
      rd_data[s] <= rd_data[s-1];
    end
  end

  assign mem_rdata = rd_vld[RDL-1] ? rd_data[RDL-1] : (32'hBAD00000 ^ gcnt);

  logic [PORTS-1:0] took_q = '0;
  always @(posedge clk) took_q <= req_valid & req_ready;

  // Reference model: pointer, expected macro drive, queue of due responses, shadow memory.
  typedef struct {
    int               due;
    int               port;
    logic             err;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t             rq[$];
  logic [WIDTH-1:0] ref_mem [HEIGHT];

  initial begin
    int               cyc, ptr_m, g, p, a;
    logic             exp_en, exp_we;
    logic [AW-1:0]    exp_addr;
    logic [WIDTH-1:0] exp_wdata, exp_rd;
    logic [MASK-1:0]  exp_mask, m;
    logic [PORTS-1:0] exp_rdy, exp_rv;
    logic             exp_err;
    rsp_t             r;
    cyc = 0; ptr_m = 0;
    exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_mask = '0;
    for (int i = 0; i < HEIGHT; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_mask}, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        ptr_m = 0; rq.delete();
        exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0; exp_mask = '0;
        continue;
      end
      g = -1;
      for (int k = 0; k < PORTS; k++) begin
        p = (ptr_m + k) % PORTS;
        if (g < 0 && req_valid[p]) g = p;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("mem_en", mem_en, exp_en);
      chk("mem_we", mem_we, exp_we);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_wdata", mem_wdata, exp_wdata);
      chk("mem_mask", mem_mask, exp_mask);
      exp_rv = '0; exp_err = 1'b0; exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        exp_rv[r.port] = 1'b1;
        exp_err = r.err;
        exp_rd = r.data;
      end
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      exp_en = 1'b0;
      if (g >= 0) begin
        ptr_m = (g + 1) % PORTS;
        a = int'(req_addr[g*AW +: AW]);
        if (a < HEIGHT) begin
          exp_en = 1'b1;
          exp_we = req_we[g];
          exp_addr = AW'(a);
          exp_wdata = req_wdata[g*WIDTH +: WIDTH];
          exp_mask = req_we[g] ? req_mask[g*MASK +: MASK] : '0;
        end
        if (req_we[g] && a < HEIGHT) begin
          m = req_mask[g*MASK +: MASK];
          for (int l = 0; l < MASK; l++)
            if (m[l]) ref_mem[a][l*LW +: LW] = req_wdata[g*WIDTH + l*LW +: LW];
        end else if (!req_we[g]) begin
          r.due = cyc + 1 + RDL;
          r.port = g;
          r.err = (a >= HEIGHT);
          r.data = (a < HEIGHT) ? ref_mem[a] : '0;
          rq.push_back(r);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, input logic [MASK-1:0] m);
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*WIDTH +: WIDTH] = d;
    req_mask[p*MASK +: MASK] = m;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    reset_n = 1'b0;
    req_valid = '1;
    at_neg();
    chk("reset_ready_gated", req_ready, '0);
    chk("reset_mem_en", mem_en, 0);
    next_cycle();
    req_valid = '0;
    next_cycle();
    reset_n = 1'b1;

    // single read of a preloaded word
    set_req(0, 1'b0, 8'd5, '0, '0);
    at_neg();
    chk("t1_ready", req_ready, 3'b001);
    next_cycle();
    req_valid = '0;
    at_neg();
    chk("t1_mem_en", mem_en, 1);
    chk("t1_mem_addr", mem_addr, 5);
    wait_cycles(3);
    at_neg();
    chk("t1_rsp_valid", rsp_valid, 3'b001);
    chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
    next_cycle();

    // masked write then read back
    set_req(1, 1'b1, 8'd3, 32'hAABBCCDD, 4'b0011);
    at_neg();
    chk("t2_wr_ready", req_ready, 3'b010);
    next_cycle();
    req_valid = '0;
    at_neg();
    chk("t2_wr_mem", {mem_en, mem_we, mem_mask}, 6'b11_0011);
    chk("t2_wr_wdata", mem_wdata, 32'hAABBCCDD);
    next_cycle();
    set_req(1, 1'b0, 8'd3, '0, 4'b1111);
    at_neg();
    chk("t2_rd_ready", req_ready, 3'b010);
    next_cycle();
    req_valid = '0;
    at_neg();
    chk("t2_rd_mask", {mem_en, mem_we, mem_mask}, 6'b10_0000);
    wait_cycles(3);
    at_neg();
    chk("t2_rsp_valid", rsp_valid, 3'b010);
    chk("t2_rdata", rsp_rdata, 32'h1122CCDD);
    next_cycle();

    // fairness between two persistent requesters
    set_req(0, 1'b0, 8'd10, '0, '0);
    set_req(1, 1'b0, 8'd20, '0, '0);
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("t3_grant", req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
      next_cycle();
    end
    req_valid[1] = 1'b0;
    next_cycle();
    req_valid = '0;
    wait_cycles(6);

    // back-to-back reads return in issue order
    for (int k = 0; k < 4; k++) begin
      req_valid = '0;
      set_req(k % PORTS, 1'b0, AW'(40 + k), '0, '0);
      next_cycle();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      logic [PORTS-1:0] oh;
      oh = '0;
      oh[k % PORTS] = 1'b1;
      at_neg();
      chk("t4_rsp_order", rsp_valid, oh);
      next_cycle();
    end

    // out-of-range read and write
    set_req(2, 1'b0, 8'd210, '0, '0);
    at_neg();
    chk("t5_rd_ready", req_ready, 3'b100);
    next_cycle();
    req_valid = '0;
    at_neg();
    chk("t5_rd_mem_en", mem_en, 0);
    wait_cycles(3);
    at_neg();
    chk("t5_rsp", {rsp_valid, rsp_err, rsp_rdata}, {3'b100, 1'b1, 32'h0});
    next_cycle();
    set_req(2, 1'b1, 8'd210, 32'hFFFFFFFF, 4'b1111);
    next_cycle();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("t5_wr_quiet", {mem_en, rsp_valid}, '0);
      next_cycle();
    end

    // reset while a read is in flight
    set_req(0, 1'b0, 8'd7, '0, '0);
    at_neg();
    chk("t6_ready", req_ready, 3'b001);
    next_cycle();
    req_valid = '0;
    at_neg();
    chk("t6_mem_en", mem_en, 1);
    #1 reset_n = 1'b0;
    #1 chk("t6_async_clear", {mem_en, rsp_valid, req_ready}, '0);
    wait_cycles(2);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("t6_no_rsp", rsp_valid, '0);
      next_cycle();
    end
    set_req(0, 1'b0, 8'd8, '0, '0);
    set_req(1, 1'b0, 8'd9, '0, '0);
    at_neg();
    chk("t6_ptr_reset", req_ready, 3'b001);
    next_cycle();
    req_valid[0] = 1'b0;
    at_neg();
    chk("t6_second", req_ready, 3'b010);
    next_cycle();
    req_valid = '0;
    wait_cycles(6);

    // randomized traffic, heavy then moderate load, one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!req_valid[i] || took_q[i]) begin
          if ($urandom_range(99) < ((c < 1000) ? 85 : 45))
            set_req(i, 1'($urandom_range(1)), AW'($urandom_range(255)),
                    WIDTH'($urandom), MASK'($urandom));
          else
            req_valid[i] = 1'b0;
        end
      end
      if (c == 1500) reset_n = 1'b0;
      if (c == 1503) reset_n = 1'b1;
      next_cycle();
    end
    for (int c = 0; c < 2 * PORTS; c++) begin
      req_valid = req_valid & ~took_q;
      next_cycle();
    end
    req_valid = '0;
    wait_cycles(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
